// File: rtl/float32_to_mxint8_quantizer.sv
// Streams BLOCK_SIZE FP32 words into one MXINT8 block: a shared E8M0 scale plus 1.6 fixed-point elements.
// Collect (BLOCK_SIZE cycles), quantize (BLOCK_SIZE cycles), then hold the result until i_ready.
module float32_to_mxint8_quantizer #(
  parameter int BLOCK_SIZE           = 32,
  parameter int SCALE_WIDTH          = 8,
  parameter int MXINT8_ELEMENT_WIDTH = 8,
  parameter int FLOAT32_WIDTH        = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [FLOAT32_WIDTH-1:0]        i_float32,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [SCALE_WIDTH-1:0]          o_scale,
  output logic [MXINT8_ELEMENT_WIDTH-1:0] o_mxint8_elements [BLOCK_SIZE-1:0]
);

  localparam int CNT_W = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {S_COLLECT, S_QUANT, S_OUTPUT} state_t;

  state_t                          state_q;
  logic [CNT_W-1:0]                count_q;
  logic [7:0]                      maxexp_q;
  logic                            nan_q;
  logic                            ready_q;
  logic                            valid_q;
  logic [SCALE_WIDTH-1:0]          scale_q;
  // Stored word: {sign, exponent, top 7 mantissa bits}.
  logic [15:0]                     buf_q   [BLOCK_SIZE-1:0];
  logic [MXINT8_ELEMENT_WIDTH-1:0] elems_q [BLOCK_SIZE-1:0];

  logic [7:0]                      in_exp;
  logic [MXINT8_ELEMENT_WIDTH-1:0] elem_d;
  logic                            unused_lsbs;

  // Mantissa bits below the round position can never change the rounded result.
  assign unused_lsbs = ^i_float32[15:0];
  assign in_exp      = i_float32[30:23];

  function automatic logic [7:0] quantize(input logic [15:0] w, input logic [7:0] mexp);
    logic [7:0] d;
    logic [7:0] r8;
    logic [7:0] qr;
    logic [6:0] qs;
    d  = mexp - w[14:7];
    r8 = {1'b1, w[6:0]} >> d[2:0];
    qr = {1'b0, r8[7:1]} + {7'd0, r8[0]};
    qs = qr[7] ? 7'd127 : qr[6:0];
    if (w[14:7] == 8'd0 || d >= 8'd8) return 8'd0;
    return w[15] ? -{1'b0, qs} : {1'b0, qs};
  endfunction

  assign elem_d = nan_q ? '0 : quantize(buf_q[count_q], maxexp_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_COLLECT;
      count_q  <= '0;
      maxexp_q <= '0;
      nan_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      scale_q  <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        buf_q[i]   <= '0;
        elems_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (i_valid) begin
            buf_q[count_q] <= i_float32[31:16];
            if (in_exp == 8'hFF) nan_q <= 1'b1;
            else if (in_exp > maxexp_q) maxexp_q <= in_exp;
            if (count_q == CNT_W'(BLOCK_SIZE - 1)) begin
              count_q <= '0;
              ready_q <= 1'b0;
              state_q <= S_QUANT;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        S_QUANT: begin
          elems_q[count_q] <= elem_d;
          if (count_q == CNT_W'(BLOCK_SIZE - 1)) begin
            count_q <= '0;
            valid_q <= 1'b1;
            scale_q <= nan_q ? '1 : maxexp_q;
            state_q <= S_OUTPUT;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (i_ready) begin
            valid_q  <= 1'b0;
            maxexp_q <= '0;
            nan_q    <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= S_COLLECT;
          end
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign o_ready           = ready_q;
  assign o_valid           = valid_q;
  assign o_scale           = scale_q;
  assign o_mxint8_elements = elems_q;

endmodule

// File: tb/tb_float32_to_mxint8_quantizer.sv
// Directed bench for the FP32 -> MXINT8 block quantizer with a 4-element block.
module tb_float32_to_mxint8_quantizer;
  localparam int BS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] din;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_scale;
  logic [7:0]  elems [BS-1:0];

  int checks = 0;
  int errors = 0;
  int stall;
  int lat;

  always #5 clk = ~clk;

  float32_to_mxint8_quantizer #(
    .BLOCK_SIZE(BS), .SCALE_WIDTH(8), .MXINT8_ELEMENT_WIDTH(8), .FLOAT32_WIDTH(32)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_float32(din),
    .o_valid(o_valid), .i_ready(i_ready), .o_scale(o_scale), .o_mxint8_elements(elems)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, output int waited);
    i_valid = 1'b1;
    din     = w;
    waited  = 0;
    while (!o_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic push4(input logic [31:0] w0, w1, w2, w3, output int waited);
    int s;
    waited = 0;
    push(w0, s); waited += s;
    push(w1, s); waited += s;
    push(w2, s); waited += s;
    push(w3, s); waited += s;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] sc,
                           input logic [7:0] e0, e1, e2, e3);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    check({tag, "_scale"}, {24'd0, o_scale}, {24'd0, sc});
    check({tag, "_e0"}, {24'd0, elems[0]}, {24'd0, e0});
    check({tag, "_e1"}, {24'd0, elems[1]}, {24'd0, e1});
    check({tag, "_e2"}, {24'd0, elems[2]}, {24'd0, e2});
    check({tag, "_e3"}, {24'd0, elems[3]}, {24'd0, e3});
  endtask

  task automatic handshake(input string tag);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_ready_rise"}, {31'd0, o_ready}, 32'd1);
  endtask

  task automatic run_block(input string tag, input logic [31:0] w0, w1, w2, w3,
                           input logic [7:0] sc, input logic [7:0] e0, e1, e2, e3);
    push4(w0, w1, w2, w3, stall);
    check({tag, "_accept_stall"}, stall, 0);
    wait_valid(lat);
    check({tag, "_latency"}, lat, BS);
    check_out(tag, sc, e0, e1, e2, e3);
    handshake(tag);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_scale", {24'd0, o_scale}, 32'd0);
    check("rst_e0", {24'd0, elems[0]}, 32'd0);
    check("rst_e3", {24'd0, elems[3]}, 32'd0);

    run_block("ones", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
              8'd127, 8'h40, 8'h40, 8'h40, 8'h40);
    check("hold_after_hs_scale", {24'd0, o_scale}, 32'd127);
    check("hold_after_hs_e0", {24'd0, elems[0]}, 32'h40);

    run_block("mixed", 32'h3F800000, 32'hBF000000, 32'h3E800000, 32'h40400000,
              8'd128, 8'h20, 8'hF0, 8'h08, 8'h60);

    run_block("round_sat", 32'h3F810000, 32'h3FFFFFFF, 32'hBFFFFFFF, 32'h3F800000,
              8'd127, 8'h41, 8'h7F, 8'h81, 8'h40);

    // 1.0 against 128.0 sits 7 binades down and rounds up to 1; denormal and -0.0 flush to 0.
    run_block("denorm_d7", 32'h43000000, 32'h3F800000, 32'h00000001, 32'h80000000,
              8'd134, 8'h40, 8'h01, 8'h00, 8'h00);

    run_block("d8_zero", 32'h43800000, 32'h3F800000, 32'hC3800000, 32'h3F800000,
              8'd135, 8'h40, 8'h00, 8'hC0, 8'h00);

    run_block("zeros", 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
              8'd0, 8'h00, 8'h00, 8'h00, 8'h00);

    run_block("nan", 32'h3F800000, 32'h7FC00000, 32'h40000000, 32'hBF800000,
              8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);

    // Backpressure: result frozen, inputs refused, NaN pulses must not leak into the next block.
    push4(32'h3F800000, 32'hBF000000, 32'h3E800000, 32'h40400000, stall);
    wait_valid(lat);
    check("bp_latency", lat, BS);
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1;
      din     = 32'h7FC00000;
      @(posedge clk); #1;
      check("bp_valid", {31'd0, o_valid}, 32'd1);
      check("bp_ready", {31'd0, o_ready}, 32'd0);
      check("bp_scale", {24'd0, o_scale}, 32'd128);
      check("bp_e1", {24'd0, elems[1]}, 32'hF0);
    end
    i_valid = 1'b0;
    handshake("bp");
    run_block("after_bp", 32'h3F810000, 32'h3FFFFFFF, 32'hBFFFFFFF, 32'h3F800000,
              8'd127, 8'h41, 8'h7F, 8'h81, 8'h40);

    // Reset after half a block: the partial words and their NaN/max exponent are discarded.
    push(32'h7FC00000, stall);
    push(32'h47800000, stall);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", {31'd0, o_ready}, 32'd1);
    run_block("post_rst", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
              8'd127, 8'h40, 8'h40, 8'h40, 8'h40);

    // Reset while a result is pending drops o_valid on the next cycle.
    push4(32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000, stall);
    wait_valid(lat);
    check("outrst_pre_valid", {31'd0, o_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("outrst_valid", {31'd0, o_valid}, 32'd0);
    check("outrst_ready", {31'd0, o_ready}, 32'd1);
    check("outrst_scale", {24'd0, o_scale}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/float32_to_mxint8_quantizer.md
Name: float32_to_mxint8_quantizer

Overview:
- Streaming encoder that accepts BLOCK_SIZE FP32 values one per cycle and produces one MXINT8 block: a shared E8M0 scale plus BLOCK_SIZE 8-bit two's-complement elements in 1.6 fixed point.
- Sits upstream of the MXINT8 datapath.
- Performs the inverse mapping of the MXINT8→FP32 reduction path: element × 2^(scale−127) reconstructs the input.

Parameters:
- BLOCK_SIZE, 32, elements per MX block (≥2).
- SCALE_WIDTH, 8, shared-scale width (E8M0).
- MXINT8_ELEMENT_WIDTH, 8, element width.
- FLOAT32_WIDTH, 32, input width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input FP32 word valid.
- o_ready  out  1  block accepts input (COLLECT state only).
- i_float32  in  FLOAT32_WIDTH  FP32 input, IEEE-754 layout.
- o_valid  out  1  block result valid.
- i_ready  in  1  downstream accepts result.
- o_scale  out  SCALE_WIDTH  shared E8M0 scale.
- o_mxint8_elements  out  MXINT8_ELEMENT_WIDTH × [BLOCK_SIZE-1:0] unpacked array; index i = i-th accepted input.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-high: one clock, one reset.
  - Reset values: state=COLLECT, o_ready=1, o_valid=0, o_scale=0, all elements=0, counter=0, running max exponent=0.
- State COLLECT:
  - o_ready=1. Each cycle with i_valid&&o_ready stores the word at buffer[count] and increments count.
  - Updates maxexp = max(maxexp, exp) for finite normals (exp in 1..254).
  - Any exp==255 (Inf/NaN) sets a sticky nan flag.
  - On the BLOCK_SIZE-th accept: count→0, go to QUANT.
- State QUANT:
  - o_ready=0. Processes one element per cycle, index 0..BLOCK_SIZE-1; exactly BLOCK_SIZE cycles.
  - Then goes to OUTPUT.
- State OUTPUT:
  - o_valid=1. o_scale and elements stable until i_valid... no: stable until i_ready sampled high.
  - On o_valid&&i_ready: o_valid→0, maxexp/nan cleared, return to COLLECT next cycle; o_ready rises that same next cycle.
  - Output registers hold their last value after handshake.
- Latency: last input accept at cycle T → o_valid high at cycle T+BLOCK_SIZE+1.
- Throughput: one block per 2·BLOCK_SIZE+1 cycles with i_ready tied high.
- Scale:
  - nan flag → o_scale=8'hFF, all elements 0.
  - No normal inputs (all zero/denormal) → o_scale=0, all elements 0.
  - Otherwise o_scale=maxexp.
- Element i:
  - exp==0 → 0 (denormals flush to zero).
  - Otherwise mag24={1,mantissa}, d=maxexp−exp.
  - Fixed value q = mag24 >> (17+d); round bit = bit (16+d) of mag24 (0 if index ≥24).
  - Round to nearest, ties away from zero: q+=round bit.
  - Saturate q to 127.
  - Element = sign ? −q : q (8-bit two's complement); −128 never produced.
  - d≥24 yields 0.
- Simultaneous events:
  - i_valid while o_ready=0: ignored, not stored.
  - Reset in any state discards the partial or pending block and clears all state; o_valid falls the cycle after reset is sampled.
- Sign of −0.0 → element 0 (never negative zero encoding).

Test Plan:
- BLOCK_SIZE=4, inputs 0x3F800000 ×4 (1.0) → o_scale=127, elements {0x40,0x40,0x40,0x40}; o_valid exactly 5 cycles after 4th accept.
- BLOCK_SIZE=4, inputs 1.0, −0.5, 0.25, 3.0 (0x3F800000, 0xBF000000, 0x3E800000, 0x40400000) → o_scale=128, elements {0x20,0xF0,0x08,0x60}.
- Rounding/saturation:
  - 0x3F810000 with max exp 127 → 0x41 (64.5 ties away → 65).
  - 0x3FFFFFFF → 0x7F (saturated 127).
  - 0xBFFFFFFF → 0x81.
- Zero/special:
  - All 0x00000000 → o_scale=0, elements 0.
  - One 0x7FC00000 in block → o_scale=0xFF, all elements 0.
- Backpressure: hold i_ready=0 for 10 cycles in OUTPUT → o_valid, o_scale, elements stable; o_ready=0; i_valid pulses ignored. Release → next block accepted starting the following cycle.
- Reset mid-COLLECT after 2 of 4 words → next 4 words form a fresh block; results match that block only.
